// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver with valid/ack host handshake and error status.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] baud_sel,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, WAIT_IDLE = 3'd5
    } state_t;

    // Even parity expected: odd count of ones over data plus parity bit is a mismatch.
    function automatic logic parity_bad(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd4, WAIT_IDLE = 3'd5
    } state_t;
`endif

    logic [1:0] sync_r;
    logic       rx_s;
    logic [8:0] tick_cnt_r;
    logic [8:0] term_s;
    logic       tick_s;
    state_t     state_r, state_nx;
    logic [3:0] s_cnt_r, s_cnt_nx;
    logic [2:0] bit_idx_r, bit_idx_nx;
    logic [7:0] shift_r, shift_nx;
    logic       par_bad_r, par_bad_nx;
    logic       deliver_s, overrun_s, frame_s;
    logic [7:0] data_out_r;
    logic       data_valid_r, parity_err_r, frame_err_r, overrun_err_r, busy_r;

    assign rx_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_r <= 2'b11;
        else      sync_r <= {sync_r[0], rx};
    end

    // Terminal count of the 16x tick divider for each baud rate.
    always_comb begin
        term_s = 9'd479;
        case (baud_sel)
            2'b00:   term_s = 9'd479;
            2'b01:   term_s = 9'd239;
            2'b10:   term_s = 9'd119;
            2'b11:   term_s = 9'd29;
            default: term_s = 9'd479;
        endcase
    end

    assign tick_s = (tick_cnt_r >= term_s);

    // Free-running oversampling counter; >= keeps a lowered terminal count from running away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        tick_cnt_r <= 9'd0;
        else if (tick_s) tick_cnt_r <= 9'd0;
        else             tick_cnt_r <= tick_cnt_r + 9'd1;
    end

    // Frame sequencing: next state, sample counters, shift register and status strobes.
    always_comb begin
        state_nx   = state_r;
        s_cnt_nx   = s_cnt_r;
        bit_idx_nx = bit_idx_r;
        shift_nx   = shift_r;
        par_bad_nx = par_bad_r;
        deliver_s  = 1'b0;
        overrun_s  = 1'b0;
        frame_s    = 1'b0;
        if (tick_s) begin
            case (state_r)
                IDLE: begin
                    if (!rx_s) begin
                        state_nx = START;
                        s_cnt_nx = 4'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                START: begin
                    if (s_cnt_r == 4'd7) begin
                        s_cnt_nx   = 4'd0;
                        bit_idx_nx = 3'd0;
                        state_nx   = rx_s ? IDLE : DATA;
                    end else begin
                        s_cnt_nx = s_cnt_r + 4'd1;
                    end
                end
                DATA: begin
                    s_cnt_nx = s_cnt_r + 4'd1;
                    if (s_cnt_r == 4'd15) begin
                        shift_nx   = {rx_s, shift_r[7:1]};
                        bit_idx_nx = bit_idx_r + 3'd1;
`ifdef UART_RX_PARITY_EN
                        state_nx   = (bit_idx_r == 3'd7) ? PARITY : DATA;
`else
                        state_nx   = (bit_idx_r == 3'd7) ? STOP : DATA;
`endif
                    end else begin
                        state_nx = DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    s_cnt_nx = s_cnt_r + 4'd1;
                    if (s_cnt_r == 4'd15) begin
                        par_bad_nx = parity_bad(shift_r, rx_s);
                        state_nx   = STOP;
                    end else begin
                        state_nx = PARITY;
                    end
                end
`endif
                STOP: begin
                    s_cnt_nx = s_cnt_r + 4'd1;
                    if (s_cnt_r == 4'd15) begin
                        if (rx_s) begin
                            // An ack on this same edge frees the holding register for the new byte.
                            deliver_s = !data_valid_r || data_ack;
                            overrun_s = data_valid_r && !data_ack;
                            state_nx  = IDLE;
                        end else begin
                            frame_s  = 1'b1;
                            state_nx = WAIT_IDLE;
                        end
                    end else begin
                        state_nx = STOP;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) state_nx = IDLE;
                    else      state_nx = WAIT_IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            s_cnt_r   <= 4'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            par_bad_r <= 1'b0;
        end else begin
            state_r   <= state_nx;
            s_cnt_r   <= s_cnt_nx;
            bit_idx_r <= bit_idx_nx;
            shift_r   <= shift_nx;
            par_bad_r <= par_bad_nx;
        end
    end

    // Host-facing output registers and handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_r    <= 8'd0;
            data_valid_r  <= 1'b0;
            parity_err_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            if (deliver_s) begin
                data_out_r   <= shift_r;
                parity_err_r <= par_bad_r;
                data_valid_r <= 1'b1;
            end else if (data_ack) begin
                data_valid_r <= 1'b0;
            end else begin
                data_valid_r <= data_valid_r;
            end
            frame_err_r   <= frame_s;
            overrun_err_r <= overrun_s;
            busy_r        <= (state_nx != IDLE);
        end
    end

    assign data_out    = data_out_r;
    assign data_valid  = data_valid_r;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_r;
`else
    assign parity_err  = 1'b0;
`endif
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames against a byte-level model of the host view.
module tb_uart_receiver;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] baud_sel;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    logic settled = 1'b0;
    logic m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic m_par = 1'b0;
    int   fe_cnt = 0, ov_cnt = 0, dv_rise_cnt = 0, dv_rise_cyc = 0;
    logic prev_dv = 1'b0;
    int   bit_clk = 1920;
    int   lat, fall;

    uart_receiver dut (
        .clk(clk), .rst(rst), .baud_sel(baud_sel), .rx(rx),
        .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
        .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
    );

    always #27 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required finish before 100000", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic logic even_bit(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Compare process: outside the stop-bit window the host view must match the model exactly.
    always @(negedge clk) begin
        if (data_valid === 1'b1 && prev_dv === 1'b0) begin
            dv_rise_cnt++;
            dv_rise_cyc = cyc;
        end
        prev_dv = data_valid;
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun_err === 1'b1) ov_cnt++;
        if (settled && rst === 1'b1) begin
            check("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("data_out", {24'd0, data_out}, {24'd0, m_data});
                check("parity_err", {31'd0, parity_err}, {31'd0, m_par});
            end
            check("quiet_pulses", {30'd0, frame_err, overrun_err}, 32'd0);
        end
    end

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit, output int latency);
        int fe0, ov0, r0, t0;
        logic ef, eo, ed;
        fe0 = fe_cnt; ov0 = ov_cnt; r0 = dv_rise_cnt; t0 = cyc;
        ef = !stop_bit;
        eo = stop_bit && m_valid;
        ed = stop_bit && !m_valid;
        drive(1'b0, bit_clk);
        for (int i = 0; i < 8; i++) drive(d[i], bit_clk);
`ifdef UART_RX_PARITY_EN
        drive(par_bit, bit_clk);
`endif
        settled = 1'b0;
        drive(stop_bit, bit_clk);
        if (ed) begin
            m_valid = 1'b1;
            m_data  = d;
`ifdef UART_RX_PARITY_EN
            m_par   = (($countones(d) + (par_bit ? 1 : 0)) % 2) == 1;
`else
            m_par   = 1'b0;
`endif
        end
        settled = 1'b1;
        check("frame_err_pulses", fe_cnt - fe0, {31'd0, ef});
        check("overrun_pulses", ov_cnt - ov0, {31'd0, eo});
        check("deliveries", dv_rise_cnt - r0, {31'd0, ed});
        latency = dv_rise_cyc - t0;
    endtask

    task automatic ack();
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        data_ack = 1'b0;
        m_valid = 1'b0;
        check("ack_clears", {31'd0, data_valid}, 32'd0);
    endtask

    task automatic idle(input int n);
        drive(1'b1, n);
    endtask

    task automatic glitch(output int fall_at);
        int t0;
        t0 = cyc;
        drive(1'b0, 500);
        rx = 1'b1;
        fall_at = -1;
        for (int i = 0; i < 20000 && fall_at < 0; i++) begin
            @(negedge clk);
            if (busy === 1'b0) fall_at = cyc - t0;
        end
        @(posedge clk);
        #1;
        check("glitch_valid", {31'd0, data_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; rx = 1'b1; data_ack = 1'b0; baud_sel = 2'b10;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_flags", {27'd0, data_valid, parity_err, frame_err, overrun_err, busy}, 32'd0);
        rst = 1'b1;
        settled = 1'b1;
        idle(40);

        // Clean byte at 9600 baud and its delivery latency
        bit_clk = 1920;
        send_frame(8'hA5, even_bit(8'hA5), 1'b1, lat);
        check("a5_data", {24'd0, data_out}, 32'hA5);
        check("a5_valid", {31'd0, data_valid}, 32'd1);
        check_range("a5_latency", lat, 18110, 18370);
        ack();
        ack();

        // Start-bit glitches at 9600, 2400 and 4800: busy drops after eight ticks
        glitch(fall);
        check_range("glitch_9600_busy_fall", fall, 960, 1084);
        baud_sel = 2'b00; bit_clk = 7680;
        idle(600);
        glitch(fall);
        check_range("glitch_2400_busy_fall", fall, 3840, 4324);
        baud_sel = 2'b01; bit_clk = 3840;
        idle(300);
        glitch(fall);
        check_range("glitch_4800_busy_fall", fall, 1920, 2164);

        // Framing error followed by a break, at 38400 baud
        baud_sel = 2'b11; bit_clk = 480;
        idle(100);
        send_frame(8'h3C, even_bit(8'h3C), 1'b0, lat);
        drive(1'b0, 5 * 480);
        check("break_busy", {31'd0, busy}, 32'd1);
        check("break_valid", {31'd0, data_valid}, 32'd0);
        idle(100);
        check("break_released_busy", {31'd0, busy}, 32'd0);
        idle(480);
        send_frame(8'h3C, even_bit(8'h3C), 1'b1, lat);
        check("3c_data", {24'd0, data_out}, 32'h3C);
        ack();

        // Overrun: second byte is dropped while the first waits for ack
        send_frame(8'h11, even_bit(8'h11), 1'b1, lat);
        send_frame(8'h22, even_bit(8'h22), 1'b1, lat);
        check("overrun_keeps_11", {24'd0, data_out}, 32'h11);
        ack();
        send_frame(8'h33, even_bit(8'h33), 1'b1, lat);
        check("33_data", {24'd0, data_out}, 32'h33);
        ack();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, lat);
        check("par_good_err", {31'd0, parity_err}, 32'd0);
        check("par_good_data", {24'd0, data_out}, 32'h07);
        ack();
        send_frame(8'h07, 1'b0, 1'b1, lat);
        check("par_bad_err", {31'd0, parity_err}, 32'd1);
        check("par_bad_data", {23'd0, data_valid, data_out}, 32'h107);
        ack();
`endif

        send_frame(8'h5A, even_bit(8'h5A), 1'b1, lat);
        check("5a_38400_data", {24'd0, data_out}, 32'h5A);
        ack();

        // Reset in the middle of the data bits
        drive(1'b0, 480);
        drive(1'b0, 480);
        drive(1'b1, 480);
        rst = 1'b0;
        #1;
        m_data = 8'h00;
        check("midrst_data_out", {24'd0, data_out}, 32'h00);
        check("midrst_flags", {27'd0, data_valid, parity_err, frame_err, overrun_err, busy}, 32'd0);
        @(posedge clk);
        #1;
        rx = 1'b1;
        rst = 1'b1;
        idle(960);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
